ram_burst_reader: RTL
=====================

RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, SHALL set the RAM address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the word width.
REQ-003 Parameter DEPTH, default 1<<ADDR_WIDTH, SHALL set the number of RAM words.
REQ-004 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be asynchronous, active-high.
REQ-006 start  in  1  SHALL request a burst; sampled only in IDLE.
REQ-007 base_addr  in  ADDR_WIDTH  SHALL give the first word address, captured with start.
REQ-008 length  in  ADDR_WIDTH+1  SHALL give the word count, 0..DEPTH, captured with start.
REQ-009 busy  out  1  SHALL be high in RUN and DONE.
REQ-010 done  out  1  SHALL be a one-cycle pulse marking burst completion.
REQ-011 read_addr  out  ADDR_WIDTH  SHALL drive the read address of the dual-port RAM.
REQ-012 ram_data  in  DATA_WIDTH  SHALL be the RAM registered output, equal to mem[A] in the cycle after read_addr=A.
REQ-013 out_data  out  DATA_WIDTH  SHALL be the stream data.
REQ-014 out_valid  out  1  SHALL qualify out_data.
REQ-015 out_ready  in  1  SHALL be the sink acceptance signal; a beat transfers when out_valid and out_ready are both high at a rising edge.

Function
REQ-016 States SHALL be IDLE, RUN, DONE; IDLE->RUN on start in IDLE; RUN->DONE once all length beats are transferred; DONE->IDLE unconditionally after one cycle.
REQ-017 done SHALL be high exactly in the DONE cycle.
REQ-018 On entering RUN, the address counter SHALL equal base_addr and the remaining-issue count SHALL equal length.
REQ-019 A read is issued in a RUN cycle when remaining>0 and (buffered+inflight<2, or buffered+inflight==2 with a beat transferring that cycle); read_addr SHALL equal the address counter in that cycle.
REQ-020 Each issue SHALL increment the address counter modulo DEPTH (DEPTH-1 wraps to 0) and decrement remaining.
REQ-021 ram_data SHALL be captured into a 2-entry FIFO in the cycle after the issue; data is never dropped or duplicated.
REQ-022 out_valid SHALL be high whenever the FIFO is non-empty; out_data SHALL be the FIFO head and SHALL hold stable while out_valid is high and out_ready is low.
REQ-023 Beats SHALL be delivered in address order.
REQ-024 Latency: start accepted at edge 0 -> first issue in cycle 1 -> first out_valid in cycle 3.
REQ-025 With out_ready held high, throughput SHALL be one beat per cycle.
REQ-026 length=0 SHALL go RUN->DONE with no issue and no out_valid; done high in cycle 2.
REQ-027 Last beat transferred at edge N -> done high in cycle N+1.
REQ-028 start while busy SHALL be ignored; base_addr and length are not recaptured.
REQ-029 When no read is issued, read_addr SHALL hold its last value.

Reset
REQ-030 reset high SHALL force IDLE immediately, without a clock edge, and clear the FIFO, counters, and in-flight flag.
REQ-031 During and after reset, busy=0, done=0, out_valid=0, out_data=0, and read_addr=0.
REQ-032 reset mid-burst SHALL abandon the burst; no beat and no done pulse follow until a new start.

Verification
REQ-033 mem[i]=i+100, base=2, length=4, out_ready=1 -> out_valid in cycles 3-6 with data 102,103,104,105; done in cycle 7.
REQ-034 DEPTH=8, base=6, length=4 -> read_addr sequence 6,7,0,1; data mem[6],mem[7],mem[0],mem[1].
REQ-035 base=0, length=8, out_ready low in cycles 4-6 -> out_data frozen while stalled; all 8 words delivered exactly once, in order.
REQ-036 length=0 -> out_valid never asserts; done in cycle 2; busy in cycles 1-2.
REQ-037 reset asserted in cycle 5 of a length-8 burst -> outputs 0 at once; no done; a new start then runs a correct burst.
REQ-038 start pulsed with base=5 during an active burst -> ignored; the active burst completes unchanged.

Source files
------------

// File: rtl/ram_burst_reader.sv
// Streams `length` consecutive words from a registered-output RAM, starting at base_addr
// and wrapping modulo DEPTH, through a 2-entry skid FIFO with valid/ready handshake.
module ram_burst_reader #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_next, last_addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count, occupancy;
  logic                  pop, push, issue;

  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign push      = inflight;
  assign read_addr = issue ? addr : last_addr;

  always_comb begin
    pop       = out_valid && out_ready;
    // A word in flight already owns a FIFO slot, so count it against capacity.
    occupancy = count + {1'b0, inflight};
    issue     = (state == RUN) && (remaining != '0) &&
                ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
    addr_next = (addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr + ADDR_WIDTH'(1);
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if ((remaining == '0) && !inflight &&
            ((count == 2'd0) || ((count == 2'd1) && pop)))
          state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      last_addr   <= '0;
      remaining   <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if ((state == IDLE) && start) begin
        addr      <= base_addr;
        remaining <= length;
      end else if (issue) begin
        addr      <= addr_next;
        remaining <= remaining - 1'b1;
        last_addr <= addr;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= ram_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
